// File: rtl/dcm_ps_stepper.sv
// DCM variable phase-shift stepper.
// Walks the DCM fine phase offset one PSEN step at a time toward a clamped signed target.
// It tracks the offset applied by completed steps and flags timeout and lock loss.
// Everything runs in the PSCLK domain. All outputs are registered.
module dcm_ps_stepper #(
  parameter int          PS_MIN  = -255,
  parameter int          PS_MAX  = 255,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       psclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       psdone,
  input  logic       go,
  input  logic [9:0] target,
  output logic       psen,
  output logic       psincdec,
  output logic [9:0] current,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLock,
    StCompare,
    StIssue,
    StWaitDone,
    StFault
  } state_e;

  state_e             state_q, state_d;
  logic signed [9:0]  tgt_q, tgt_d;
  logic signed [9:0]  cur_q, cur_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               inc_q, inc_d;
  logic               err_q, err_d;
  logic               psen_q, psen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Saturate a raw two's-complement request into the legal offset window.
  function automatic logic signed [9:0] clamp(input logic [9:0] t);
    int v;
    v = int'($signed(t));
    if (v < PS_MIN) begin
      v = PS_MIN;
    end else if (v > PS_MAX) begin
      v = PS_MAX;
    end
    return v[9:0];
  endfunction

  // Next-state, step bookkeeping and look-ahead of the registered outputs.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    inc_d   = inc_q;
    err_d   = err_q;

    if (go) begin
      tgt_d = clamp(target);
    end

    case (state_q)
      StIdle, StFault: begin
        if (go) begin
          state_d = StWaitLock;
          err_d   = 1'b0;
        end
      end
      StWaitLock: begin
        if (locked) begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (cur_q == tgt_q) begin
          // DONE was raised by look-ahead for this very cycle.
          state_d = StIdle;
        end else if (!locked) begin
          state_d = StWaitLock;
          cur_d   = '0;
        end else begin
          inc_d   = (cur_q < tgt_q);
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = '0;
        if (!locked) begin
          state_d = StWaitLock;
          cur_d   = '0;
        end else begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        // Lock loss wins over a simultaneous PSDONE: a relocked DCM restarts at zero.
        if (!locked) begin
          state_d = StWaitLock;
          cur_d   = '0;
        end else if (psdone) begin
          cur_d   = inc_q ? (cur_q + 10'sd1) : (cur_q - 10'sd1);
          state_d = StCompare;
        end else if (cnt_q == CntLast) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StFault && state_q != StFault) begin
      err_d = 1'b1;
    end

    psen_d = (state_d == StIssue);
    busy_d = (state_d != StIdle) && (state_d != StFault);
    done_d = (state_d == StCompare) && (cur_d == tgt_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge psclk) begin
    if (rst) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
      err_q   <= 1'b0;
      psen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
      err_q   <= err_d;
      psen_q  <= psen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign psen     = psen_q;
  assign psincdec = inc_q;
  assign current  = cur_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dcm_ps_stepper.sv
// Directed bench for dcm_ps_stepper with a small DCM PSDONE responder.
module tb_dcm_ps_stepper;

  logic       psclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       psdone = 1'b0;
  logic       go = 1'b0;
  logic [9:0] target = '0;
  logic       psen;
  logic       psincdec;
  logic [9:0] current;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_fail = 0;

  // Monitor counters, cleared by the tests.
  int psen_cnt = 0;
  int inc_cnt = 0;
  int dec_cnt = 0;
  int done_cnt = 0;
  int viol_cnt = 0;
  logic psen_prev = 1'b0;
  logic auto_en = 1'b0;

  dcm_ps_stepper #(
    .PS_MIN (-255),
    .PS_MAX (255),
    .TIMEOUT(16)
  ) dut (
    .psclk   (psclk),
    .rst     (rst),
    .locked  (locked),
    .psdone  (psdone),
    .go      (go),
    .target  (target),
    .psen    (psen),
    .psincdec(psincdec),
    .current (current),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 psclk = ~psclk;

  // Count pulses mid-cycle, away from the active edge.
  always @(negedge psclk) begin
    if (psen === 1'b1) begin
      psen_cnt++;
      if (psincdec === 1'b1) inc_cnt++;
      else dec_cnt++;
      if (psen_prev === 1'b1) viol_cnt++;
    end
    psen_prev = psen;
    if (done === 1'b1) done_cnt++;
  end

  // DCM model: PSDONE two cycles after each PSEN.
  initial begin
    forever begin
      @(posedge psclk); #1;
      if (auto_en && psen === 1'b1) begin
        @(posedge psclk); #1;
        @(posedge psclk); #1;
        psdone = 1'b1;
        @(posedge psclk); #1;
        psdone = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge psclk); #1;
  endtask

  task automatic clear_counts();
    psen_cnt = 0;
    inc_cnt  = 0;
    dec_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    locked = 1'b1;
    tick();
    tick();
    n_cmp++; if (psen !== 1'b0) begin n_fail++; $display("FAIL reset_psen got %b want 0", psen); end
    n_cmp++; if (psincdec !== 1'b0) begin n_fail++; $display("FAIL reset_psincdec got %b want 0", psincdec); end
    n_cmp++; if (current !== 10'd0) begin n_fail++; $display("FAIL reset_current got %h want 000", current); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    tick();
  endtask

  // Walk 0 -> +3: each step takes COMPARE, ISSUE and two WAIT_DONE cycles.
  task automatic test_step_up();
    int k;
    auto_en = 1'b1;
    clear_counts();
    go = 1'b1; target = 10'd3;
    tick();
    go = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 100) begin tick(); k++; end
    n_cmp++; if (k !== 14) begin n_fail++; $display("FAIL up_latency got %0d want 14", k); end
    n_cmp++; if (current !== 10'd3) begin n_fail++; $display("FAIL up_current got %h want 003", current); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy_at_done got %b want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL up_busy_after got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL up_done_after got %b want 0", done); end
    repeat (4) tick();
    n_cmp++; if (psen_cnt !== 3) begin n_fail++; $display("FAIL up_psen_count got %0d want 3", psen_cnt); end
    n_cmp++; if (inc_cnt !== 3) begin n_fail++; $display("FAIL up_inc_count got %0d want 3", inc_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL up_done_count got %0d want 1", done_cnt); end
  endtask

  // From +3 to -300, clamped to -255: 258 decrements.
  task automatic test_clamp_down();
    int k;
    clear_counts();
    go = 1'b1; target = 10'h2D4;  // -300
    tick();
    go = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 2000) begin tick(); k++; end
    n_cmp++; if (k !== 1034) begin n_fail++; $display("FAIL clamp_latency got %0d want 1034", k); end
    n_cmp++; if (current !== 10'h301) begin n_fail++; $display("FAIL clamp_current got %h want 301", current); end
    repeat (4) tick();
    n_cmp++; if (psen_cnt !== 258) begin n_fail++; $display("FAIL clamp_psen_count got %0d want 258", psen_cnt); end
    n_cmp++; if (dec_cnt !== 258) begin n_fail++; $display("FAIL clamp_dec_count got %0d want 258", dec_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL clamp_done_count got %0d want 1", done_cnt); end
  endtask

  // PSDONE withheld: 16 WAIT_DONE cycles, ERR visible 17 cycles after PSEN.
  task automatic test_timeout();
    int k;
    auto_en = 1'b0;
    clear_counts();
    go = 1'b1; target = 10'h306;  // -250
    tick();
    go = 1'b0;
    k = 0;
    while (psen !== 1'b1 && k < 20) begin tick(); k++; end
    n_cmp++; if (k >= 20) begin n_fail++; $display("FAIL to_psen_wait got %0d cycles want <20", k); end
    k = 0;
    while (err !== 1'b1 && k < 60) begin tick(); k++; end
    n_cmp++; if (k !== 17) begin n_fail++; $display("FAIL to_latency got %0d want 17", k); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy got %b want 0", busy); end
    repeat (20) tick();
    n_cmp++; if (psen_cnt !== 1) begin n_fail++; $display("FAIL to_psen_count got %0d want 1", psen_cnt); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got %b want 1", err); end
    n_cmp++; if (current !== 10'h301) begin n_fail++; $display("FAIL to_current got %h want 301", current); end
    // Restart out of FAULT.
    auto_en = 1'b1;
    clear_counts();
    go = 1'b1; target = 10'h306;
    tick();
    go = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear got %b want 0", err); end
    k = 1;
    while (done !== 1'b1 && k < 200) begin tick(); k++; end
    n_cmp++; if (k !== 22) begin n_fail++; $display("FAIL to_restart_latency got %0d want 22", k); end
    n_cmp++; if (current !== 10'h306) begin n_fail++; $display("FAIL to_restart_current got %h want 306", current); end
    repeat (4) tick();
    n_cmp++; if (inc_cnt !== 5) begin n_fail++; $display("FAIL to_restart_inc got %0d want 5", inc_cnt); end
  endtask

  // Lock drops in WAIT_DONE at CURRENT=5 while heading for 10.
  task automatic test_lock_loss();
    int k;
    go = 1'b1; target = 10'd10;
    tick();
    go = 1'b0;
    k = 0;
    while (!(psen === 1'b1 && current === 10'd5) && k < 2000) begin tick(); k++; end
    n_cmp++; if (k >= 2000) begin n_fail++; $display("FAIL ll_reach5 got %0d cycles want <2000", k); end
    tick();
    locked = 1'b0;
    tick();
    n_cmp++; if (current !== 10'd0) begin n_fail++; $display("FAIL ll_current_zero got %h want 000", current); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ll_busy got %b want 1", busy); end
    clear_counts();
    repeat (10) tick();
    n_cmp++; if (psen_cnt !== 0) begin n_fail++; $display("FAIL ll_psen_unlocked got %0d want 0", psen_cnt); end
    n_cmp++; if (current !== 10'd0) begin n_fail++; $display("FAIL ll_late_psdone got %h want 000", current); end
    locked = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 200) begin tick(); k++; end
    n_cmp++; if (current !== 10'd10) begin n_fail++; $display("FAIL ll_relock_current got %h want 00a", current); end
    repeat (4) tick();
    n_cmp++; if (inc_cnt !== 10) begin n_fail++; $display("FAIL ll_relock_inc got %0d want 10", inc_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ll_done_count got %0d want 1", done_cnt); end
  endtask

  // GO +8, then GO -2 during the third step: peak 3, then five decrements.
  task automatic test_retarget();
    int k;
    int peak;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    go = 1'b1; target = 10'd8;
    tick();
    go = 1'b0;
    k = 0;
    while (!(psen === 1'b1 && current === 10'd2) && k < 100) begin tick(); k++; end
    n_cmp++; if (k >= 100) begin n_fail++; $display("FAIL rt_reach2 got %0d cycles want <100", k); end
    tick();
    clear_counts();
    peak = 2;
    go = 1'b1; target = 10'h3FE;  // -2
    tick();
    go = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      if (int'($signed(current)) > peak) peak = int'($signed(current));
      tick();
      k++;
    end
    n_cmp++; if (peak !== 3) begin n_fail++; $display("FAIL rt_peak got %0d want 3", peak); end
    n_cmp++; if (current !== 10'h3FE) begin n_fail++; $display("FAIL rt_current got %h want 3fe", current); end
    repeat (4) tick();
    n_cmp++; if (dec_cnt !== 5) begin n_fail++; $display("FAIL rt_dec_count got %0d want 5", dec_cnt); end
    n_cmp++; if (inc_cnt !== 0) begin n_fail++; $display("FAIL rt_inc_count got %0d want 0", inc_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rt_done_count got %0d want 1", done_cnt); end
  endtask

  // Spurious PSDONE in IDLE, then RST in the middle of a walk.
  task automatic test_spurious_and_reset();
    int k;
    auto_en = 1'b0;
    psdone = 1'b1;
    tick();
    psdone = 1'b0;
    tick();
    n_cmp++; if (current !== 10'h3FE) begin n_fail++; $display("FAIL sp_current got %h want 3fe", current); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sp_busy got %b want 0", busy); end
    auto_en = 1'b1;
    go = 1'b1; target = 10'd20;
    tick();
    go = 1'b0;
    k = 0;
    while (current !== 10'd4 && k < 200) begin tick(); k++; end
    n_cmp++; if (k >= 200) begin n_fail++; $display("FAIL mr_reach4 got %0d cycles want <200", k); end
    rst = 1'b1;
    tick();
    n_cmp++; if (current !== 10'd0) begin n_fail++; $display("FAIL mr_current got %h want 000", current); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy got %b want 0", busy); end
    n_cmp++; if (psen !== 1'b0) begin n_fail++; $display("FAIL mr_psen got %b want 0", psen); end
    n_cmp++; if (psincdec !== 1'b0) begin n_fail++; $display("FAIL mr_psincdec got %b want 0", psincdec); end
    rst = 1'b0;
    clear_counts();
    repeat (20) tick();
    n_cmp++; if (psen_cnt !== 0) begin n_fail++; $display("FAIL mr_psen_after got %0d want 0", psen_cnt); end
    n_cmp++; if (current !== 10'd0) begin n_fail++; $display("FAIL mr_current_after got %h want 000", current); end
  endtask

  // TARGET equal to CURRENT while locked: DONE two cycles after GO, no PSEN.
  task automatic test_equal_target();
    clear_counts();
    go = 1'b1; target = 10'd0;
    tick();
    go = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL eq_done_early got %b want 0", done); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL eq_done got %b want 1", done); end
    repeat (4) tick();
    n_cmp++; if (psen_cnt !== 0) begin n_fail++; $display("FAIL eq_psen_count got %0d want 0", psen_cnt); end
    n_cmp++; if (viol_cnt !== 0) begin n_fail++; $display("FAIL psen_back_to_back got %0d want 0", viol_cnt); end
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_clamp_down();
    test_timeout();
    test_lock_loss();
    test_retarget();
    test_spurious_and_reset();
    test_equal_target();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
